adc_scan_seq: RTL and testbench

//  Self-timed scan sequencer for ADC082S021/ADC1x8S02x-family SPI ADCs. Owns the SPI

---
 rtl/adc_scan_seq_if.sv | 35 +++
 rtl/adc_scan_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_scan_seq_if
// Desc     : Control, ADC pin and sample-output bundle for adc_scan_seq.
// Revision : 1.0  initial release
// ============================================================================
interface adc_scan_seq_if #(
    parameter int NCH = 2,
    parameter int RES = 8
);
    logic           enable;
    logic           single;
    logic [NCH-1:0] chmask;
    logic           csn;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic           smp_valid;
    logic [2:0]     smp_chan;
    logic [RES-1:0] smp_data;
    logic           scan_done;
    logic           busy;

    // slave: the sequencer itself; master: controller, ADC and sample consumer
    modport slave (
        input  enable, single, chmask, miso,
        output csn, sclk, mosi, smp_valid, smp_chan, smp_data, scan_done, busy
    );
    modport master (
        output enable, single, chmask, miso,
        input  csn, sclk, mosi, smp_valid, smp_chan, smp_data, scan_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_scan_seq
// Desc     : Self-timed SPI scan sequencer for ADC082S021/ADC1x8S02x ADCs,
//            tracking the one-frame address pipeline so samples carry their channel.
// Revision : 1.0  initial release
// ============================================================================
module adc_scan_seq #(
    parameter int NCH    = 2,
    parameter int RES    = 8,
    parameter int CLKDIV = 4,
    parameter int GAP    = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    adc_scan_seq_if.slave bus
);
    localparam int c_CMAX = (CLKDIV > GAP) ? CLKDIV : GAP;
    localparam int c_CW   = $clog2(c_CMAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [c_CW-1:0] r_cnt, w_cnt;
    logic [3:0]      r_bit, w_bit;
    logic            r_csn, w_csn;
    logic            r_sclk, w_sclk;
    logic            r_mosi, w_mosi;
    logic [11:0]     r_rx, w_rx;
    logic [NCH-1:0]  r_mask, w_mask;
    logic [2:0]      r_addr, w_addr;
    logic [2:0]      r_prev_addr, w_prev_addr;
    logic            r_prev_last, w_prev_last;
    logic            r_prime, w_prime;
    logic            r_smp_valid, w_smp_valid;
    logic [2:0]      r_smp_chan, w_smp_chan;
    logic [RES-1:0]  r_smp_data, w_smp_data;
    logic            r_scan_done, w_scan_done;
    logic            r_busy, w_busy;

    logic [15:0]     w_tx;
    logic [NCH-1:0]  w_newmask;
    logic            w_last;
    logic            w_div_end;
    logic            w_gap_end;
    logic            w_start;
    logic            w_frame_done;

    function automatic logic [2:0] f_first(input logic [NCH-1:0] m);
        f_first = 3'd0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) f_first = 3'(i);
    endfunction

    // lowest enabled channel above a, wrapping to the first enabled one
    function automatic logic [2:0] f_next(input logic [NCH-1:0] m, input logic [2:0] a);
        f_next = f_first(m);
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i] && (i > int'(a))) f_next = 3'(i);
    endfunction

    function automatic logic f_is_last(input logic [NCH-1:0] m, input logic [2:0] a);
        f_is_last = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (m[i] && (i > int'(a))) f_is_last = 1'b0;
    endfunction

    assign w_div_end    = (r_cnt == c_CW'(CLKDIV - 1));
    assign w_gap_end    = (r_cnt == c_CW'(GAP - 1));
    assign w_start      = (bus.enable | bus.single) & (|bus.chmask);
    // the frame in flight returns the last channel of its scan
    assign w_frame_done = ~r_prime & r_prev_last;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_bit       = r_bit;
        w_csn       = r_csn;
        w_sclk      = r_sclk;
        w_mosi      = r_mosi;
        w_rx        = r_rx;
        w_mask      = r_mask;
        w_addr      = r_addr;
        w_prev_addr = r_prev_addr;
        w_prev_last = r_prev_last;
        w_prime     = r_prime;
        w_smp_valid = 1'b0;
        w_smp_chan  = r_smp_chan;
        w_smp_data  = r_smp_data;
        w_scan_done = 1'b0;
        w_busy      = r_busy;
        w_tx        = {2'b00, r_addr, 11'd0};
        w_newmask   = (|bus.chmask) ? bus.chmask : r_mask;
        w_last      = f_is_last(r_mask, r_addr);

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state = S_SETUP;
                    w_cnt   = '0;
                    w_csn   = 1'b0;
                    w_mosi  = 1'b0;     // tx[15] is a fixed zero
                    w_busy  = 1'b1;
                    w_mask  = bus.chmask;
                    w_addr  = f_first(bus.chmask);
                    w_prime = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                    w_bit   = 4'd0;
                    w_sclk  = 1'b0;
                    w_mosi  = w_tx[15];
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    w_cnt = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                        w_rx   = {r_rx[10:0], bus.miso};
                        if (r_bit == 4'd15) w_state = S_HOLD;
                    end else begin
                        w_sclk = 1'b0;
                        w_bit  = r_bit + 4'd1;
                        w_mosi = w_tx[4'd15 - (r_bit + 4'd1)];
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if ((r_cnt == '0) && !r_prime) begin
                    w_smp_valid = 1'b1;
                    w_smp_chan  = r_prev_addr;
                    w_smp_data  = r_rx[11:12-RES];
                    w_scan_done = r_prev_last;
                end
                if (w_div_end) begin
                    w_state = S_GAP;
                    w_cnt   = '0;
                    w_csn   = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_cnt = '0;
                    if (w_frame_done && !bus.enable) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                    end else begin
                        w_state     = S_SETUP;
                        w_csn       = 1'b0;
                        w_mosi      = 1'b0;
                        w_prime     = 1'b0;
                        w_prev_addr = r_addr;
                        w_prev_last = w_last;
                        // after the last channel, this frame primes the next scan
                        if (w_last) begin
                            w_mask = w_newmask;
                            w_addr = f_first(w_newmask);
                        end else begin
                            w_addr = f_next(r_mask, r_addr);
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 4'd0;
            r_csn       <= 1'b1;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rx        <= '0;
            r_mask      <= '0;
            r_addr      <= 3'd0;
            r_prev_addr <= 3'd0;
            r_prev_last <= 1'b0;
            r_prime     <= 1'b0;
            r_smp_valid <= 1'b0;
            r_smp_chan  <= 3'd0;
            r_smp_data  <= '0;
            r_scan_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_bit       <= w_bit;
            r_csn       <= w_csn;
            r_sclk      <= w_sclk;
            r_mosi      <= w_mosi;
            r_rx        <= w_rx;
            r_mask      <= w_mask;
            r_addr      <= w_addr;
            r_prev_addr <= w_prev_addr;
            r_prev_last <= w_prev_last;
            r_prime     <= w_prime;
            r_smp_valid <= w_smp_valid;
            r_smp_chan  <= w_smp_chan;
            r_smp_data  <= w_smp_data;
            r_scan_done <= w_scan_done;
            r_busy      <= w_busy;
        end
    end

    assign bus.csn       = r_csn;
    assign bus.sclk      = r_sclk;
    assign bus.mosi      = r_mosi;
    assign bus.smp_valid = r_smp_valid;
    assign bus.smp_chan  = r_smp_chan;
    assign bus.smp_data  = r_smp_data;
    assign bus.scan_done = r_scan_done;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_adc_scan_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_seq
// Desc     : Directed bench for adc_scan_seq with a bit-level ADC pin model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_scan_seq;
    localparam int NCH    = 2;
    localparam int RES    = 8;
    localparam int CLKDIV = 2;
    localparam int GAP    = 2;

    logic clk = 1'b0;
    logic rst;

    adc_scan_seq_if #(.NCH(NCH), .RES(RES)) bus ();

    adc_scan_seq #(.NCH(NCH), .RES(RES), .CLKDIV(CLKDIV), .GAP(GAP)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // observation state of the ADC/consumer model
    int   cyc = 0;
    int   q_addr[$], q_low[$], q_rise[$];
    int   s_chan[$], s_data[$], s_cyc[$], s_done[$];
    int   viol = 0;
    bit   busy_seen = 1'b0;
    int   csn_rise_cyc = 0, busy_fall_cyc = 0;
    int   nfall = 0, nrise = 0, lowlen = 0;
    logic p_csn = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;
    logic [15:0] word = 16'd0, din = 16'd0;
    logic [2:0]  prev_a = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC: DOUT word = {4'b0, data, 4'b0} of the address sent in the previous frame
    always @(negedge clk) begin
        cyc++;
        if (!bus.csn) begin
            if (p_csn) begin
                nfall  = 0;
                nrise  = 0;
                lowlen = 0;
                din    = 16'd0;
                word   = (prev_a == 3'd0) ? 16'h0A50 : 16'h03C0;
                bus.miso = word[15];
            end
            lowlen++;
            if (!p_sclk && bus.sclk) begin
                nrise++;
                din = {din[14:0], bus.mosi};
                if (bus.mosi !== p_mosi) viol++;
            end
            if (!p_csn && p_sclk && bus.sclk && (bus.mosi !== p_mosi)) viol++;
            if (p_sclk && !bus.sclk) begin
                bus.miso = word[4'(15 - nfall)];
                nfall++;
            end
        end else if (!p_csn) begin
            q_addr.push_back(int'(din[13:11]));
            q_low.push_back(lowlen);
            q_rise.push_back(nrise);
            prev_a       = din[13:11];
            csn_rise_cyc = cyc;
        end
        if (bus.smp_valid === 1'b1) begin
            s_chan.push_back(int'(bus.smp_chan));
            s_data.push_back(int'(bus.smp_data));
            s_cyc.push_back(cyc);
            s_done.push_back(int'(bus.scan_done));
        end
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        if (p_busy && !bus.busy) busy_fall_cyc = cyc;
        p_csn  = bus.csn;
        p_sclk = bus.sclk;
        p_mosi = bus.mosi;
        p_busy = bus.busy;
    end

    task automatic clear_obs();
        q_addr.delete(); q_low.delete(); q_rise.delete();
        s_chan.delete(); s_data.delete(); s_cyc.delete(); s_done.delete();
        viol = 0;
        busy_seen = 1'b0;
    endtask

    task automatic start(input string tag, input logic [1:0] m, input logic en, input logic sg);
        @(negedge clk);
        bus.chmask = m;
        bus.enable = en;
        bus.single = sg;
        @(negedge clk);
        bus.single = 1'b0;
        check({tag, "_csn_fall"}, 32'(bus.csn), (m == 2'b00) ? 32'd1 : 32'd0);
        check({tag, "_busy_rise"}, 32'(bus.busy), (m == 2'b00) ? 32'd0 : 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((bus.busy !== 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frames(input string tag, input int n, input int exp_a[5]);
        check({tag, "_frames"}, 32'(q_addr.size()), 32'(n));
        for (int i = 0; i < q_addr.size() && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(exp_a[i]));
            check($sformatf("%s_csnlow%0d", tag, i), 32'(q_low[i]), 32'(33 * CLKDIV));
            check($sformatf("%s_rises%0d", tag, i), 32'(q_rise[i]), 32'd16);
        end
        check({tag, "_mosi_stable"}, 32'(viol), 32'd0);
    endtask

    task automatic check_smp(input string tag, input int n, input int exp_c[4], input int exp_d[4],
                             input int exp_s[4]);
        check({tag, "_nsmp"}, 32'(s_chan.size()), 32'(n));
        for (int i = 0; i < s_chan.size() && i < n; i++) begin
            check($sformatf("%s_chan%0d", tag, i), 32'(s_chan[i]), 32'(exp_c[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(s_data[i]), 32'(exp_d[i]));
            check($sformatf("%s_done%0d", tag, i), 32'(s_done[i]), 32'(exp_s[i]));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.single = 1'b0;
        bus.chmask = 2'b00;
        bus.miso   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(bus.csn), 32'd1);
        check("rst_sclk", 32'(bus.sclk), 32'd1);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_smp_valid", 32'(bus.smp_valid), 32'd0);
        check("rst_scan_done", 32'(bus.scan_done), 32'd0);
        check("rst_smp_chan", 32'(bus.smp_chan), 32'd0);
        check("rst_smp_data", 32'(bus.smp_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single scan, both channels: priming + 2 frames
        clear_obs();
        start("t2", 2'b11, 1'b0, 1'b1);
        wait_idle("t2", 1000);
        check_frames("t2", 3, '{0, 1, 0, 0, 0});
        check_smp("t2", 2, '{0, 1, 0, 0}, '{8'hA5, 8'h3C, 0, 0}, '{0, 1, 0, 0});
        check("t2_busy_after_gap", 32'(busy_fall_cyc - csn_rise_cyc), 32'(GAP));

        // single scan, channel 1 only
        clear_obs();
        start("t3", 2'b10, 1'b0, 1'b1);
        wait_idle("t3", 1000);
        check_frames("t3", 2, '{1, 1, 0, 0, 0});
        check_smp("t3", 1, '{1, 0, 0, 0}, '{8'h3C, 0, 0, 0}, '{1, 0, 0, 0});

        // continuous, dropped after the third sample (mid second scan)
        clear_obs();
        start("t4", 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 1000 && s_chan.size() < 3; i++) @(negedge clk);
        bus.enable = 1'b0;
        wait_idle("t4", 1000);
        check_frames("t4", 5, '{0, 1, 0, 1, 0});
        check_smp("t4", 4, '{0, 1, 0, 1}, '{8'hA5, 8'h3C, 8'hA5, 8'h3C}, '{0, 1, 0, 1});
        for (int i = 1; i < s_cyc.size(); i++)
            check($sformatf("t4_period%0d", i), 32'(s_cyc[i] - s_cyc[i-1]), 32'(33 * CLKDIV + GAP));

        // empty mask: no bus activity
        clear_obs();
        start("t5", 2'b00, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_frames", 32'(q_addr.size()), 32'd0);
        check("t5_busy_seen", 32'(busy_seen), 32'd0);
        check("t5_csn", 32'(bus.csn), 32'd1);

        // async reset in the middle of a frame
        clear_obs();
        start("t1", 2'b11, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_async_csn", 32'(bus.csn), 32'd1);
        check("t1_async_sclk", 32'(bus.sclk), 32'd1);
        check("t1_async_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("t1_no_smp", 32'(s_chan.size()), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end
endmodule
`default_nettype wire
